// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared core constants and fetch state encoding
package instruction_fetch_pkg;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;
  localparam logic [INSTR_W-1:0] RESET_ADDR = 32'h0000_0000;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/instruction_fetch_buffer.sv
// fetch_buffer: prefetch FIFO of {pc, instr} entries with one slot reservable for the in-flight fetch
module fetch_buffer import instruction_fetch_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_push,
  input  logic                 i_pop,
  input  logic                 i_flush,
  input  logic                 i_reserve,
  input  logic [2*INSTR_W-1:0] i_data,
  output logic [2*INSTR_W-1:0] o_head,
  output logic                 o_empty,
  output logic                 o_full
);
  localparam int AW = $clog2(DEPTH);
  logic [2*INSTR_W-1:0] r_mem [DEPTH];
  logic [AW:0] r_rd, r_wr, w_count;
  logic w_push, w_pop;
  assign w_count = r_wr - r_rd;
  assign o_empty = w_count == '0;
  // full counts the reserved slot, so a new fetch is only issued when its data will fit
  assign o_full = int'(w_count) + int'(i_reserve) >= DEPTH;
  assign o_head = r_mem[r_rd[AW-1:0]];
  assign w_pop = i_pop && !o_empty && !i_flush;
  assign w_push = i_push && !i_flush && (int'(w_count) < DEPTH || w_pop);
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rd <= '0;
      r_wr <= '0;
    end else begin
      r_rd <= r_rd + (AW+1)'(w_pop);
      r_wr <= r_wr + (AW+1)'(w_push);
    end
  end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetches instruction words into a prefetch buffer and presents one per cycle to decode
module instruction_fetch import instruction_fetch_pkg::*; #(
  parameter logic [INSTR_W-1:0] RESET_ADDRESS = RESET_ADDR,
  parameter int                 BUFFER_DEPTH  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetchEnable,
  input  logic               jumpEnable,
  input  logic [INSTR_W-1:0] jumpAddress,
  input  logic               pipeAdvance,
  output logic [INSTR_W-1:0] currentInstruction,
  output logic [INSTR_W-1:0] currentPC,
  output logic               stall,
  output logic               addressMisaligned,
  output logic               fetchRequest,
  output logic [INSTR_W-1:0] fetchAddress,
  input  logic               fetchAck,
  input  logic [INSTR_W-1:0] fetchData
);
  fetch_state_t r_state, w_next;
  logic [INSTR_W-1:0] r_pc, r_addr, w_pc_next;
  logic r_misaligned;
  logic w_stall, w_push, w_pop, w_issue, w_empty, w_full;
  logic [2*INSTR_W-1:0] w_head;
  assign w_stall = w_empty || r_misaligned;
  assign w_pop = pipeAdvance && !w_stall;
  assign w_push = r_state == REQUEST && fetchAck;
  assign w_issue = fetchEnable && !r_misaligned && !jumpEnable && (!w_full || w_pop);
  fetch_buffer #(.DEPTH(BUFFER_DEPTH)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_flush  (jumpEnable),
    .i_reserve(r_state == REQUEST),
    .i_data   ({r_addr, fetchData}),
    .o_head   (w_head),
    .o_empty  (w_empty),
    .o_full   (w_full)
  );
  always_comb begin
    w_next = r_state;
    w_pc_next = jumpEnable ? {jumpAddress[INSTR_W-1:2], 2'b00} : w_push ? r_pc + 32'd4 : r_pc;
    case (r_state)
      IDLE:    w_next = w_issue ? REQUEST : IDLE;
      REQUEST: w_next = jumpEnable ? (fetchAck ? IDLE : DISCARD)
                      : fetchAck ? (w_issue ? REQUEST : IDLE) : REQUEST;
      DISCARD: w_next = fetchAck ? IDLE : DISCARD;
      default: w_next = IDLE;
    endcase
  end
  // r_addr is separate from r_pc so a discarded request keeps its old address after a redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc <= RESET_ADDRESS;
      r_addr <= RESET_ADDRESS;
      r_misaligned <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pc <= w_pc_next;
      if (w_next == REQUEST) r_addr <= w_pc_next;
      if (jumpEnable) r_misaligned <= |jumpAddress[1:0];
    end
  end
  assign fetchRequest = r_state != IDLE;
  assign fetchAddress = r_addr;
  assign stall = w_stall;
  assign addressMisaligned = r_misaligned;
  assign currentInstruction = w_stall ? '0 : w_head[INSTR_W-1:0];
  assign currentPC = w_stall ? '0 : w_head[2*INSTR_W-1:INSTR_W];
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized and directed checks against an in-order PC stream model
module tb_instruction_fetch;
  logic clk = 1'b0, rst = 1'b1, fetchEnable = 1'b0, jumpEnable = 1'b0, pipeAdvance = 1'b0, force_ack = 1'b0;
  logic [31:0] jumpAddress = '0;
  logic [31:0] currentInstruction, currentPC, fetchAddress, fetchData;
  logic stall, addressMisaligned, fetchRequest, fetchAck;
  int checks = 0, failures = 0;
  int lat_cfg = 0, r_lat = 0, cnt;
  bit rand_lat = 1'b0;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk(clk), .rst(rst), .fetchEnable(fetchEnable), .jumpEnable(jumpEnable),
    .jumpAddress(jumpAddress), .pipeAdvance(pipeAdvance),
    .currentInstruction(currentInstruction), .currentPC(currentPC), .stall(stall),
    .addressMisaligned(addressMisaligned), .fetchRequest(fetchRequest),
    .fetchAddress(fetchAddress), .fetchAck(fetchAck), .fetchData(fetchData)
  );

  // memory: acks after a configurable number of wait cycles, word = address ^ KEY
  assign fetchAck = (fetchRequest && cnt >= (rand_lat ? r_lat : lat_cfg)) || force_ack;
  assign fetchData = fetchAddress ^ KEY;
  always @(posedge clk) begin
    cnt <= (rst || !fetchRequest || fetchAck) ? 0 : cnt + 1;
    if (fetchAck) r_lat <= int'($urandom_range(0, 3));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    fetchEnable = 1'b1;
    rst = 1'b1;
    tick;
    tick;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL reset_stall got=%0h exp=1", stall); end
    checks++; if (fetchRequest !== 1'b0) begin failures++; $display("FAIL reset_req got=%0h exp=0", fetchRequest); end
    checks++; if (addressMisaligned !== 1'b0) begin failures++; $display("FAIL reset_mis got=%0h exp=0", addressMisaligned); end
    checks++; if (currentInstruction !== 32'h0) begin failures++; $display("FAIL reset_instr got=%0h exp=0", currentInstruction); end
    checks++; if (currentPC !== 32'h0) begin failures++; $display("FAIL reset_pc got=%0h exp=0", currentPC); end
  endtask

  task automatic test_zero_wait;
    logic [31:0] exp;
    lat_cfg = 0; rand_lat = 1'b0; pipeAdvance = 1'b1; fetchEnable = 1'b1;
    do_reset;
    tick;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL zw_first_stall got=%0h exp=1", stall); end
    tick;
    checks++; if (stall !== 1'b0 || currentPC !== 32'h0) begin failures++; $display("FAIL zw_first_pc got=%0h/%0h exp=0/0", stall, currentPC); end
    exp = 32'h4;
    for (int i = 0; i < 20; i++) begin
      tick;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL zw_stall got=%0h exp=0", stall); end
      checks++; if (currentPC !== exp) begin failures++; $display("FAIL zw_pc got=%0h exp=%0h", currentPC, exp); end
      checks++; if (currentInstruction !== (exp ^ KEY)) begin failures++; $display("FAIL zw_instr got=%0h exp=%0h", currentInstruction, exp ^ KEY); end
      exp += 4;
    end
  endtask

  task automatic test_latency;
    logic [31:0] exp, prev_addr;
    logic prev_wait;
    int last;
    lat_cfg = 3; pipeAdvance = 1'b1; fetchEnable = 1'b1;
    do_reset;
    exp = 0; last = -1; prev_wait = 1'b0; prev_addr = '0;
    for (int i = 0; i < 60; i++) begin
      tick;
      if (prev_wait && fetchRequest) begin
        checks++; if (fetchAddress !== prev_addr) begin failures++; $display("FAIL lat_addr_hold got=%0h exp=%0h", fetchAddress, prev_addr); end
      end
      prev_wait = fetchRequest && !fetchAck;
      prev_addr = fetchAddress;
      if (!stall) begin
        checks++; if (currentPC !== exp) begin failures++; $display("FAIL lat_pc got=%0h exp=%0h", currentPC, exp); end
        checks++; if (currentInstruction !== (exp ^ KEY)) begin failures++; $display("FAIL lat_instr got=%0h exp=%0h", currentInstruction, exp ^ KEY); end
        if (last >= 0) begin
          checks++; if (i - last !== 4) begin failures++; $display("FAIL lat_gap got=%0d exp=4", i - last); end
        end
        last = i;
        exp += 4;
      end
    end
    checks++; if (exp < 32'd52) begin failures++; $display("FAIL lat_throughput got=%0d exp>=13", exp / 4); end
  endtask

  task automatic test_backpressure;
    logic [31:0] exp;
    lat_cfg = 0; pipeAdvance = 1'b0; fetchEnable = 1'b1;
    do_reset;
    for (int i = 1; i <= 12; i++) begin
      tick;
      if (i >= 3) begin
        checks++; if (fetchRequest !== 1'b0) begin failures++; $display("FAIL bp_req got=%0h exp=0", fetchRequest); end
      end
      if (i >= 2) begin
        checks++; if (stall !== 1'b0 || currentPC !== 32'h0) begin failures++; $display("FAIL bp_hold got=%0h/%0h exp=0/0", stall, currentPC); end
      end
    end
    pipeAdvance = 1'b1;
    exp = 0;
    for (int i = 0; i < 16; i++) begin
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL bp_resume_stall got=%0h exp=0", stall); end
      checks++; if (currentPC !== exp) begin failures++; $display("FAIL bp_resume_pc got=%0h exp=%0h", currentPC, exp); end
      exp += 4;
      tick;
    end
  endtask

  task automatic test_redirect;
    logic [31:0] exp;
    bit seen;
    lat_cfg = 2; pipeAdvance = 1'b1; fetchEnable = 1'b1;
    do_reset;
    exp = 0;
    for (int i = 0; i < 40 && !(fetchRequest && fetchAddress == 32'h8); i++) begin
      if (!stall) begin
        checks++; if (currentPC !== exp) begin failures++; $display("FAIL rd_pre_pc got=%0h exp=%0h", currentPC, exp); end
        exp += 4;
      end
      tick;
    end
    checks++; if (!(fetchRequest && fetchAddress == 32'h8)) begin failures++; $display("FAIL rd_wait_req8 got=%0h exp=8", fetchAddress); end
    jumpEnable = 1'b1; jumpAddress = 32'h100;
    tick;
    jumpEnable = 1'b0;
    checks++; if (fetchRequest !== 1'b1 || fetchAddress !== 32'h8) begin failures++; $display("FAIL rd_discard_hold got=%0h/%0h exp=1/8", fetchRequest, fetchAddress); end
    exp = 32'h100; seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (fetchRequest && fetchAddress != 32'h8 && !seen) begin
        seen = 1'b1;
        checks++; if (fetchAddress !== 32'h100) begin failures++; $display("FAIL rd_next_req got=%0h exp=100", fetchAddress); end
      end
      if (!stall) begin
        checks++; if (currentPC === 32'h8) begin failures++; $display("FAIL rd_dropped_presented got=%0h exp=not 8", currentPC); end
        checks++; if (currentPC !== exp) begin failures++; $display("FAIL rd_pc got=%0h exp=%0h", currentPC, exp); end
        exp += 4;
      end
      tick;
    end
    checks++; if (exp <= 32'h100) begin failures++; $display("FAIL rd_no_progress got=%0h exp>100", exp); end
  endtask

  task automatic test_misaligned;
    logic [31:0] exp;
    bit seen;
    lat_cfg = 0; pipeAdvance = 1'b1; fetchEnable = 1'b1;
    do_reset;
    repeat (5) tick;
    jumpEnable = 1'b1; jumpAddress = 32'h102;
    tick;
    jumpEnable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (addressMisaligned !== 1'b1) begin failures++; $display("FAIL mis_flag got=%0h exp=1", addressMisaligned); end
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL mis_stall got=%0h exp=1", stall); end
      checks++; if (fetchRequest !== 1'b0) begin failures++; $display("FAIL mis_req got=%0h exp=0", fetchRequest); end
      checks++; if (currentPC !== 32'h0 || currentInstruction !== 32'h0) begin failures++; $display("FAIL mis_outputs got=%0h/%0h exp=0/0", currentPC, currentInstruction); end
      tick;
    end
    jumpEnable = 1'b1; jumpAddress = 32'h200;
    tick;
    jumpEnable = 1'b0;
    checks++; if (addressMisaligned !== 1'b0) begin failures++; $display("FAIL mis_clear got=%0h exp=0", addressMisaligned); end
    exp = 32'h200; seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (fetchRequest && !seen) begin
        seen = 1'b1;
        checks++; if (fetchAddress !== 32'h200) begin failures++; $display("FAIL mis_resume_req got=%0h exp=200", fetchAddress); end
      end
      if (!stall) begin
        checks++; if (currentPC !== exp) begin failures++; $display("FAIL mis_resume_pc got=%0h exp=%0h", currentPC, exp); end
        exp += 4;
      end
      tick;
    end
    checks++; if (exp <= 32'h200) begin failures++; $display("FAIL mis_no_progress got=%0h exp>200", exp); end
  endtask

  task automatic test_reset_midrequest;
    lat_cfg = 3; pipeAdvance = 1'b1; fetchEnable = 1'b1;
    do_reset;
    for (int i = 0; i < 20 && !(fetchRequest && fetchAddress == 32'h4); i++) tick;
    checks++; if (!(fetchRequest && fetchAddress == 32'h4)) begin failures++; $display("FAIL rm_wait_req got=%0h exp=4", fetchAddress); end
    rst = 1'b1;
    tick;
    rst = 1'b0; force_ack = 1'b1;
    checks++; if (stall !== 1'b1 || fetchRequest !== 1'b0) begin failures++; $display("FAIL rm_reset_ctl got=%0h/%0h exp=1/0", stall, fetchRequest); end
    checks++; if (currentPC !== 32'h0 || currentInstruction !== 32'h0 || addressMisaligned !== 1'b0) begin failures++; $display("FAIL rm_reset_out got=%0h/%0h/%0h exp=0/0/0", currentPC, currentInstruction, addressMisaligned); end
    tick;
    force_ack = 1'b0;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rm_ack_ignored got=%0h exp=1", stall); end
    checks++; if (fetchRequest !== 1'b1 || fetchAddress !== 32'h0) begin failures++; $display("FAIL rm_first_req got=%0h/%0h exp=1/0", fetchRequest, fetchAddress); end
    for (int i = 0; i < 10 && stall; i++) tick;
    checks++; if (stall !== 1'b0 || currentPC !== 32'h0) begin failures++; $display("FAIL rm_first_pc got=%0h/%0h exp=0/0", stall, currentPC); end
  endtask

  task automatic test_random;
    logic [31:0] exp, target;
    int presented;
    rand_lat = 1'b1; pipeAdvance = 1'b1; fetchEnable = 1'b1;
    do_reset;
    exp = 0; presented = 0;
    for (int i = 0; i < 400; i++) begin
      pipeAdvance = ($urandom % 4) != 0;
      fetchEnable = ($urandom % 8) != 0;
      target = (i == 200) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
      jumpEnable = (i == 200) || (($urandom % 40) == 0);
      jumpAddress = target;
      if (!stall) begin
        checks++; if (currentPC !== exp) begin failures++; $display("FAIL rnd_pc got=%0h exp=%0h", currentPC, exp); end
        checks++; if (currentInstruction !== (exp ^ KEY)) begin failures++; $display("FAIL rnd_instr got=%0h exp=%0h", currentInstruction, exp ^ KEY); end
        presented++;
      end else begin
        checks++; if (currentPC !== 32'h0 || currentInstruction !== 32'h0) begin failures++; $display("FAIL rnd_stall_zero got=%0h/%0h exp=0/0", currentPC, currentInstruction); end
      end
      if (jumpEnable) exp = target;
      else if (!stall && pipeAdvance) exp += 4;
      tick;
    end
    jumpEnable = 1'b0;
    checks++; if (presented < 50) begin failures++; $display("FAIL rnd_progress got=%0d exp>=50", presented); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_zero_wait;
    test_latency;
    test_backpressure;
    test_redirect;
    test_misaligned;
    test_reset_midrequest;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Producer side of the decode interface. Fetches 32-bit RV32I instruction words from the instruction memory port, buffers them with their PCs, and presents one instruction per cycle to the decode stage.
- Drives the decode stage's instruction word and stall inputs.
- Handles control-flow redirects (jump/branch/trap) by flushing buffered and in-flight fetches.
- Sits between the core's instruction memory interface and the decode/execute stage.

Parameters:
- RESET_ADDRESS, 32'h0000_0000, first fetch address after reset.
- BUFFER_DEPTH, 2, prefetch buffer entries; power of two, at least 2.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous reset, active-high
- fetchEnable  input  1  core running; 0 pauses issuing new requests
- jumpEnable  input  1  redirect request, single-cycle pulse
- jumpAddress  input  32  redirect target
- pipeAdvance  input  1  decode/execute consumed the presented instruction this cycle
- currentInstruction  output  32  instruction word to decode
- currentPC  output  32  PC of currentInstruction
- stall  output  1  no valid instruction presented
- addressMisaligned  output  1  sticky: last redirect target had [1:0] != 0
- fetchRequest  output  1  memory request
- fetchAddress  output  32  word-aligned request address
- fetchAck  input  1  memory returns data this cycle
- fetchData  input  32  returned word, valid when fetchAck is high

Behaviour:
- Reset (synchronous, rst high at clk edge):
  - buffer empty; fetchPC = RESET_ADDRESS.
  - state IDLE; fetchRequest = 0; addressMisaligned = 0; stall = 1.
  - currentInstruction = 0; currentPC = 0.
  - Any in-flight request is abandoned. An ack arriving in the first cycle after reset is ignored.
- States:
  - IDLE: no request outstanding. Go to REQUEST when fetchEnable, buffer not full (counting the in-flight slot), !addressMisaligned and no redirect this cycle.
  - REQUEST: fetchRequest = 1, fetchAddress = fetchPC, both held stable until fetchAck.
    - On ack: push {fetchPC, fetchData}; fetchPC += 4 (wraps modulo 2^32).
    - Go to REQUEST again if the issue condition still holds, else IDLE.
  - DISCARD: entered when a redirect occurs while in REQUEST without a same-cycle ack.
    - fetchRequest stays high at the old address until ack; that data is dropped; then go to IDLE.
- Ack timing: an ack in the same cycle fetchRequest first rises is legal (zero-wait memory). At most one request is outstanding.
- Push/present latency: data pushed at the edge sampling fetchAck; stall falls in the following cycle.
  - Zero-wait memory sustains 1 instruction/cycle once the buffer is primed.
- Presentation:
  - stall = buffer empty OR addressMisaligned.
  - When stall = 0: currentInstruction/currentPC = buffer head. When stall = 1 both are driven 0.
  - Pop on pipeAdvance && !stall. pipeAdvance while stall is ignored.
  - Push and pop in the same cycle leave the count unchanged.
  - Full buffer: no new request is issued. An in-flight ack always has a reserved slot.
- Redirect (jumpEnable):
  - Flush the buffer; the same cycle's pop and push are both discarded.
  - fetchPC = {jumpAddress[31:2], 2'b00}.
  - Redirect has priority over pipeAdvance and fetchAck.
  - A redirect with a same-cycle ack: data dropped, next state IDLE.
  - If jumpAddress[1:0] != 0: set addressMisaligned (stall held, no fetching).
  - addressMisaligned clears only on an aligned redirect or reset.
- fetchEnable low:
  - Only stops new requests. An outstanding request completes and its data is pushed.
  - The buffer keeps draining via pipeAdvance.
- Compressed instructions are not expanded. Words are passed through untouched; decode flags them.

Decomposition:
- Shared core package holds:
  - instruction width (32);
  - NOP encoding 32'h0000_0013;
  - RESET_ADDRESS default;
  - fetch state encoding (IDLE=0, REQUEST=1, DISCARD=2).
- One sub-module is natural: fetch_buffer. It is a synchronous FIFO with a 64-bit entry {pc, instr}, push/pop/flush, full/empty and count, plus a one-slot reservation input for the in-flight request.

Test Plan:
- Zero-wait memory returning word = address ^ 32'hA5A5_0000, pipeAdvance held high -> first instruction at PC 0 appears 2 cycles after rst falls; then PCs 0,4,8,... one per cycle with no stall.
- Memory with 3-cycle ack latency, pipeAdvance high -> fetchAddress held stable during the wait; stall pattern 1,1,1,0 repeating; no PC skipped or duplicated.
- pipeAdvance low for 10 cycles -> after BUFFER_DEPTH pushes fetchRequest stays 0; currentPC stays 0 and stall stays 0; resuming delivers 4,8,... in order.
- jumpEnable with jumpAddress 32'h100 while a request to 32'h8 is pending with ack 2 cycles later -> that data is dropped; the next request is to 32'h100; first presented PC is 32'h100; no 0x8 entry ever presented.
- jumpAddress 32'h102 -> addressMisaligned = 1, stall = 1, no requests. A later jump to 32'h200 clears the flag and fetch resumes at 32'h200.
- rst asserted mid-REQUEST with an ack in the next cycle -> ack ignored; first request after reset goes to RESET_ADDRESS; outputs at reset values.
